// File: rtl/cr_axi4s2_mstr_pkg.sv
// cr_axi4s2_mstr_pkg: default sizing and count-width helper for the stream master.
package cr_axi4s2_mstr_pkg;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_AFULL = 1;
  localparam int DEF_AEMPTY = 1;
  localparam int FRM_W = 16;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/cr_structs.sv
// cr_structs: shared AXI4-stream datapath bus and ready types.
package cr_structs;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [3:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  tuser;
    logic [3:0]  tkeep;
    logic [3:0]  tstrb;
    logic [31:0] tdata;
  } axi4s_dp_bus_t;
  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;
endpackage

// File: rtl/cr_axi4s2_mstr_if.sv
// cr_axi4s2_mstr_if: producer push side, status flags and outbound stream channel.
interface cr_axi4s2_mstr_if;
  import cr_structs::*;
  logic          axi4s_mstr_wr;
  axi4s_dp_bus_t axi4s_mstr_in;
  logic          axi4s_mstr_full;
  logic          axi4s_mstr_afull;
  logic          axi4s_mstr_aempty;
  logic          axi4s_mstr_idle;
  logic          axi4s_mstr_ovfl;
  logic [15:0]   axi4s_mstr_frm_cnt;
  axi4s_dp_bus_t axi4s_ob_out;
  axi4s_dp_rdy_t axi4s_ob_in;
  modport master (
    input  axi4s_mstr_wr, axi4s_mstr_in, axi4s_ob_in,
    output axi4s_mstr_full, axi4s_mstr_afull, axi4s_mstr_aempty, axi4s_mstr_idle,
    output axi4s_mstr_ovfl, axi4s_mstr_frm_cnt, axi4s_ob_out
  );
  modport slave (
    output axi4s_mstr_wr, axi4s_mstr_in, axi4s_ob_in,
    input  axi4s_mstr_full, axi4s_mstr_afull, axi4s_mstr_aempty, axi4s_mstr_idle,
    input  axi4s_mstr_ovfl, axi4s_mstr_frm_cnt, axi4s_ob_out
  );
endinterface

// File: rtl/cr_axi4s2_mstr_fifo.sv
// cr_axi4s2_mstr_fifo: flop-array circular buffer with count and registered flags.
module cr_axi4s2_mstr_fifo
  import cr_structs::*, cr_axi4s2_mstr_pkg::*;
#(
  parameter int N_ENTRIES = DEF_ENTRIES,
  parameter int N_AFULL_VAL = DEF_AFULL,
  parameter int N_AEMPTY_VAL = DEF_AEMPTY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  axi4s_dp_bus_t wr_data,
  output axi4s_dp_bus_t rd_data,
  output logic          empty,
  output logic          full,
  output logic          afull,
  output logic          aempty
);
  localparam int CW = cnt_w(N_ENTRIES);
  localparam int AW = CW - 1;
  axi4s_dp_bus_t mem [N_ENTRIES];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  assign cnt_nxt = cnt + CW'(push) - CW'(pop);
  assign empty = cnt == '0;
  assign rd_data = mem[rd_ptr];
  // flags are decoded from the next count so they move on the same edge as the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt    <= cnt_nxt;
      full   <= cnt_nxt == CW'(N_ENTRIES);
      afull  <= cnt_nxt >= CW'(N_ENTRIES - N_AFULL_VAL);
      aempty <= cnt_nxt <= CW'(N_AEMPTY_VAL);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/cr_axi4s2_mstr.sv
// cr_axi4s2_mstr: buffered AXI4-stream transmit endpoint with registered output stage.
module cr_axi4s2_mstr
  import cr_structs::*, cr_axi4s2_mstr_pkg::*;
#(
  parameter int N_ENTRIES = DEF_ENTRIES,
  parameter int N_AFULL_VAL = DEF_AFULL,
  parameter int N_AEMPTY_VAL = DEF_AEMPTY
) (
  input logic              clk,
  input logic              rst_n,
  cr_axi4s2_mstr_if.master bus
);
  logic          push, pop, hs, empty, full, ovfl;
  logic [FRM_W-1:0] frm_cnt;
  axi4s_dp_bus_t head, or_q, or_nxt;
  assign hs   = or_q.tvalid & bus.axi4s_ob_in.tready;
  assign push = bus.axi4s_mstr_wr & ~full;
  assign pop  = ~empty & (~or_q.tvalid | hs);
  cr_axi4s2_mstr_fifo #(
    .N_ENTRIES(N_ENTRIES),
    .N_AFULL_VAL(N_AFULL_VAL),
    .N_AEMPTY_VAL(N_AEMPTY_VAL)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .wr_data(bus.axi4s_mstr_in),
    .rd_data(head),
    .empty(empty),
    .full(full),
    .afull(bus.axi4s_mstr_afull),
    .aempty(bus.axi4s_mstr_aempty)
  );
  // the tvalid bit of the output register doubles as its occupancy flag
  always_comb begin
    or_nxt = pop ? head : or_q;
    or_nxt.tvalid = pop | (or_q.tvalid & ~hs);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q    <= '0;
      ovfl    <= 1'b0;
      frm_cnt <= '0;
    end else begin
      or_q    <= or_nxt;
      ovfl    <= ovfl | (bus.axi4s_mstr_wr & full);
      frm_cnt <= frm_cnt + FRM_W'(hs & or_q.tlast);
    end
  end
  assign bus.axi4s_ob_out       = or_q;
  assign bus.axi4s_mstr_full    = full;
  assign bus.axi4s_mstr_idle    = empty & ~or_q.tvalid;
  assign bus.axi4s_mstr_ovfl    = ovfl;
  assign bus.axi4s_mstr_frm_cnt = frm_cnt;
endmodule

// File: tb/tb_cr_axi4s2_mstr.sv
// tb_cr_axi4s2_mstr: self-checking bench with a beat scoreboard and flag vector table.
module tb_cr_axi4s2_mstr;
  import cr_structs::*;
  typedef struct {
    logic [31:0] d;
    logic tv, f, af, ae, ov;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cr_axi4s2_mstr_if bus();
  cr_axi4s2_mstr #(.N_ENTRIES(16), .N_AFULL_VAL(1), .N_AEMPTY_VAL(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.master)
  );
  int n_chk = 0;
  int n_err = 0;
  int n_hs = 0;
  axi4s_dp_bus_t exp_q[$];
  logic [15:0] exp_frm = '0;
  logic stall = 1'b0;
  axi4s_dp_bus_t prev_ob = '0;
  vec_t vt[18];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic axi4s_dp_bus_t mk_beat(input logic [31:0] d, input logic last);
    axi4s_dp_bus_t b;
    b.tvalid = 1'b0;
    b.tlast = last;
    b.tid = d[3:0];
    b.tdest = d[7:4];
    b.tuser = d[11:8];
    b.tkeep = d[15:12];
    b.tstrb = ~d[15:12];
    b.tdata = d;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] d, input logic last, input logic accept);
    axi4s_dp_bus_t e;
    bus.axi4s_mstr_wr = 1'b1;
    bus.axi4s_mstr_in = mk_beat(d, last);
    e = mk_beat(d, last);
    e.tvalid = 1'b1;
    if (accept) exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || !bus.axi4s_mstr_idle) && c < budget) begin
      step();
      c++;
    end
    chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_drain_idle"}, 64'(bus.axi4s_mstr_idle), 64'd1);
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ob"}, 64'(bus.axi4s_ob_out), 64'd0);
    chk({p, "_idle"}, 64'(bus.axi4s_mstr_idle), 64'd1);
    chk({p, "_aempty"}, 64'(bus.axi4s_mstr_aempty), 64'd1);
    chk({p, "_afull"}, 64'(bus.axi4s_mstr_afull), 64'd0);
    chk({p, "_full"}, 64'(bus.axi4s_mstr_full), 64'd0);
    chk({p, "_ovfl"}, 64'(bus.axi4s_mstr_ovfl), 64'd0);
    chk({p, "_frm"}, 64'(bus.axi4s_mstr_frm_cnt), 64'd0);
  endtask

  // scoreboard: every handshake must carry the oldest accepted beat; stalled beats must hold
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) chk("stable", 64'(bus.axi4s_ob_out), 64'(prev_ob));
      if (bus.axi4s_ob_out.tvalid && bus.axi4s_ob_in.tready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL extra_beat: got %h expected no beat", bus.axi4s_ob_out);
        end else begin
          axi4s_dp_bus_t e;
          e = exp_q.pop_front();
          chk("beat", 64'(bus.axi4s_ob_out), 64'(e));
          if (e.tlast) exp_frm = exp_frm + 16'd1;
        end
      end
      stall = bus.axi4s_ob_out.tvalid && !bus.axi4s_ob_in.tready;
      prev_ob = bus.axi4s_ob_out;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    int pushed;
    int cyc;
    for (int k = 1; k <= 18; k++) begin
      vt[k-1].d = 32'h100 + 32'(k);
      vt[k-1].tv = k >= 2;
      vt[k-1].ae = k <= 2;
      vt[k-1].af = k >= 16;
      vt[k-1].f = k >= 17;
      vt[k-1].ov = k >= 18;
    end
    bus.axi4s_mstr_wr = 1'b0;
    bus.axi4s_mstr_in = '0;
    bus.axi4s_ob_in = '0;
    repeat (3) step();
    chk_reset("rst_hold");
    rst_n = 1'b1;
    step();
    chk_reset("rst_rel");

    bus.axi4s_ob_in.tready = 1'b1;
    push_beat(32'hA1, 1'b0, 1'b1);
    step();
    chk("lat_e0_tv", 64'(bus.axi4s_ob_out.tvalid), 64'd0);
    push_beat(32'hA2, 1'b0, 1'b1);
    step();
    chk("lat_e1_tv", 64'(bus.axi4s_ob_out.tvalid), 64'd1);
    chk("lat_e1_d", 64'(bus.axi4s_ob_out.tdata), 64'hA1);
    push_beat(32'hA3, 1'b0, 1'b1);
    step();
    chk("lat_e2_d", 64'(bus.axi4s_ob_out.tdata), 64'hA2);
    bus.axi4s_mstr_wr = 1'b0;
    step();
    chk("lat_e3_d", 64'(bus.axi4s_ob_out.tdata), 64'hA3);
    step();
    chk("lat_e4_tv", 64'(bus.axi4s_ob_out.tvalid), 64'd0);
    chk("lat_e4_idle", 64'(bus.axi4s_mstr_idle), 64'd1);

    bus.axi4s_ob_in.tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push_beat(vt[i].d, 1'b0, i < 17);
      step();
      chk($sformatf("fill%0d_tv", i + 1), 64'(bus.axi4s_ob_out.tvalid), 64'(vt[i].tv));
      if (vt[i].tv) chk($sformatf("fill%0d_data", i + 1), 64'(bus.axi4s_ob_out.tdata), 64'h101);
      chk($sformatf("fill%0d_aempty", i + 1), 64'(bus.axi4s_mstr_aempty), 64'(vt[i].ae));
      chk($sformatf("fill%0d_afull", i + 1), 64'(bus.axi4s_mstr_afull), 64'(vt[i].af));
      chk($sformatf("fill%0d_full", i + 1), 64'(bus.axi4s_mstr_full), 64'(vt[i].f));
      chk($sformatf("fill%0d_ovfl", i + 1), 64'(bus.axi4s_mstr_ovfl), 64'(vt[i].ov));
      chk($sformatf("fill%0d_idle", i + 1), 64'(bus.axi4s_mstr_idle), 64'd0);
    end
    bus.axi4s_mstr_wr = 1'b0;
    bus.axi4s_ob_in.tready = 1'b1;
    wait_drain("fill", 40);
    chk("ovfl_sticky", 64'(bus.axi4s_mstr_ovfl), 64'd1);

    h0 = n_hs;
    for (int i = 0; i < 12; i++) begin
      push_beat(32'h200 + 32'(i), (i % 4) == 3, 1'b1);
      step();
    end
    bus.axi4s_mstr_wr = 1'b0;
    step();
    step();
    chk("throughput", 64'(n_hs - h0), 64'd12);
    wait_drain("frame", 20);
    chk("frm3", 64'(bus.axi4s_mstr_frm_cnt), 64'd3);

    force dut.frm_cnt = 16'hFFFF;
    step();
    release dut.frm_cnt;
    exp_frm = 16'hFFFF;
    chk("frm_forced", 64'(bus.axi4s_mstr_frm_cnt), 64'hFFFF);
    push_beat(32'h300, 1'b1, 1'b1);
    step();
    bus.axi4s_mstr_wr = 1'b0;
    wait_drain("wrap", 20);
    chk("frm_wrap", 64'(bus.axi4s_mstr_frm_cnt), 64'd0);

    pushed = 0;
    cyc = 0;
    while (pushed < 200 && cyc < 5000) begin
      if (!bus.axi4s_mstr_afull && $urandom_range(0, 3) != 0) begin
        push_beat($urandom, $urandom_range(0, 3) == 0, 1'b1);
        pushed++;
      end else begin
        bus.axi4s_mstr_wr = 1'b0;
      end
      bus.axi4s_ob_in.tready = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    bus.axi4s_mstr_wr = 1'b0;
    bus.axi4s_ob_in.tready = 1'b1;
    chk("rand_pushed", 64'(pushed), 64'd200);
    wait_drain("rand", 100);
    chk("rand_frm", 64'(bus.axi4s_mstr_frm_cnt), 64'(exp_frm));

    bus.axi4s_ob_in.tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_beat(32'h400 + 32'(i), 1'b1, 1'b1);
      step();
    end
    bus.axi4s_mstr_wr = 1'b0;
    chk("mid_tv", 64'(bus.axi4s_ob_out.tvalid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    chk_reset("mid_rst");
    rst_n = 1'b1;
    bus.axi4s_ob_in.tready = 1'b1;
    h0 = n_hs;
    repeat (10) step();
    chk("mid_stale", 64'(n_hs - h0), 64'd0);
    chk("mid_idle", 64'(bus.axi4s_mstr_idle), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cr_axi4s2_mstr.md
# cr_axi4s2_mstr

AXI4-stream master (transmit) endpoint: accepts beats from an internal producer through a simple push interface, buffers them in a flop-based FIFO, and drives them onto an outbound `axi4s_dp_bus_t` channel with full `tvalid`/`tready` flow control. It is the egress counterpart of the buffered AXI4-stream slave endpoint. It sits at block outputs where a producer cannot absorb downstream backpressure cycle by cycle.

## Interface
- `N_ENTRIES`, 16: FIFO depth in beats, excluding the output register; power of two, at least 4.
- `N_AFULL_VAL`, 1: `axi4s_mstr_afull` asserts when FIFO count ≥ N_ENTRIES − N_AFULL_VAL.
- `N_AEMPTY_VAL`, 1: `axi4s_mstr_aempty` asserts when FIFO count ≤ N_AEMPTY_VAL.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `axi4s_mstr_wr` in 1: push one beat this cycle.
- `axi4s_mstr_in` in `axi4s_dp_bus_t`: beat payload. The `tvalid` field is ignored.
- `axi4s_mstr_full` out 1: FIFO count == N_ENTRIES (registered).
- `axi4s_mstr_afull` out 1: almost full (registered).
- `axi4s_mstr_aempty` out 1: almost empty (registered).
- `axi4s_mstr_idle` out 1: FIFO empty and output register empty.
- `axi4s_mstr_ovfl` out 1: sticky; set by a push while full. Cleared only by reset.
- `axi4s_mstr_frm_cnt` out 16: count of `tlast` beats accepted downstream; wraps at 2^16.
- `axi4s_ob_out` out `axi4s_dp_bus_t`: outbound beat.
- `axi4s_ob_in` in `axi4s_dp_rdy_t`: downstream `tready`.

## Operation
- **Push:**
  - Push when `axi4s_mstr_wr` is high and `axi4s_mstr_full` is low. The beat is written at the write pointer, and the pointer increments modulo N_ENTRIES.
  - A push while full is dropped and sets `ovfl`. This holds even when a pop occurs in the same cycle, because `full` is the registered count.
- **Output register (OR):**
  - `axi4s_ob_out` is driven directly from flops. `tvalid` is the OR-valid bit, and the other fields come from the OR data.
  - The OR loads from the FIFO head when the FIFO is non-empty and either (OR empty) or (`tvalid` & `tready`). A load is a FIFO pop.
  - When `tvalid` & `tready` and the FIFO is empty, OR-valid clears.
- **AXI rules:**
  - `tvalid` never depends combinationally on `tready`.
  - Once `tvalid` is high, every field of `axi4s_ob_out` holds stable until the handshake cycle.
  - Beats leave in push order with no reordering and no duplication.
- **Count:**
  - FIFO count is a (log2(N_ENTRIES)+1)-bit register, incremented on push, decremented on pop, unchanged on simultaneous push+pop.
  - `full`, `afull` and `aempty` are registered decodes of the next count.
- **Frame counter:** `frm_cnt` increments on `tvalid` & `tready` & `tlast`, and wraps 0xFFFF→0.
- **Reset (including mid-operation):**
  - All pointers, the count, OR-valid, `ovfl` and `frm_cnt` go to 0. Buffered beats are discarded.
  - Output reset values: `axi4s_ob_out` all zero, `full`=0, `afull`=0, `aempty`=1, `idle`=1, `ovfl`=0, `frm_cnt`=0.
- **Total capacity:** N_ENTRIES + 1 beats.

## Timing
- **Latency:** a push at edge N into an empty block reaches the FIFO at N. The OR loads at edge N+1, and `tvalid` is high in the cycle after N+1, i.e. 2 edges after the push. There is no bypass path.
- **Throughput:** sustained 1 beat/cycle with `tready` held high and continuous pushes.
- **Flag update timing:**
  - `full`, `afull` and `aempty` update on the edge that changes the count.
  - A producer honouring `afull` with N_AFULL_VAL ≥ 1 never overflows.
- **Wrap-around:** pointers wrap silently. Push and pop on the same slot in the same cycle cannot occur, because pop requires a non-empty FIFO.

## Structure
- `axi4s_dp_bus_t` and `axi4s_dp_rdy_t` come from the shared `cr_structs` package. No new typedefs.
- Sub-module `cr_axi4s2_mstr_fifo` is a flop-array circular buffer with pointers, count and flags.
- The top level holds the OR, pop logic, `ovfl` and `frm_cnt`.

## Test plan
- **Reset:** hold `rst_n`=0, then release → `axi4s_ob_out`=0, `idle`=1, `aempty`=1, `full`=0, `ovfl`=0, `frm_cnt`=0.
- **Latency and ordering:** `tready`=1; push tdata 0xA1, 0xA2, 0xA3 on consecutive cycles starting edge 0 → `tvalid` high starting the cycle after edge 1, carrying A1, A2, A3 back-to-back. `idle` returns to 1 afterward.
- **Backpressure fill:** defaults, `tready`=0; push 18 beats back-to-back.
  - Beat 1 sits in the OR.
  - `afull` rises when count reaches 15.
  - `full` rises at 16.
  - Beat 18 is dropped and `ovfl`=1.
  - Raising `tready` then delivers exactly beats 1–17 in order.
- **Stability:** random `tready` toggling over 200 random beats → no field changes while `tvalid` & !`tready`. The output sequence equals the push sequence.
- **Frame count:** send 3 frames of 4 beats with `tlast` on each 4th beat → `frm_cnt`=3. With the counter forced to 0xFFFF, one more `tlast` handshake → 0.
- **Reset mid-operation:** assert `rst_n` low with 10 beats buffered and `tvalid` high → outputs return to reset values on the next cycle. After release, no stale beat appears.
